// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronizes the serial line, centres on each bit and
// presents the byte with a one-cycle valid strobe; bad stop bits pulse o_frame_err.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_d,
    output logic [7:0] o_rx_d,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    // state | meaning
    // IDLE  | waiting for a high-to-low edge on the synchronized line
    // START | counting to mid start bit, then confirming it is still low
    // DATA  | sampling 8 data bits, LSB first, one per bit period
    // STOP  | sampling the stop bit and reporting byte or framing error
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bidx;
    logic [7:0]       r_sh;
    logic             r_rx_m;
    logic             r_rx_s;
    logic             r_rx_p;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_p <= 1'b1;
        end else begin
            r_rx_m <= i_rx_d;
            r_rx_s <= r_rx_m;
            r_rx_p <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bidx      <= 3'd0;
            r_sh        <= 8'h00;
            o_rx_d      <= 8'h00;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_p && !r_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= DATA;
                            r_bidx  <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_sh  <= {r_rx_s, r_sh[7:1]};
                        if (r_bidx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bidx <= r_bidx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (r_rx_s) begin
                            o_rx_d     <= r_sh;
                            o_rx_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);

endmodule
